// File: rtl/select_encode_scoreboard_pkg.sv
// select_encode_scoreboard_pkg: shared field positions and one-hot decode helper
package select_encode_scoreboard_pkg;
  localparam int MAX_REGS = 64;
  localparam int MAX_IDX_W = 6;
  localparam int RA_LSB_DEF = 23;
  localparam int RB_LSB_DEF = 19;
  localparam int RC_LSB_DEF = 15;
  function automatic logic [MAX_REGS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return {{(MAX_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/select_encode_scoreboard_decoder.sv
// onehot_decoder: enabled index to one-hot register strobe decode
module onehot_decoder
  import select_encode_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W = $clog2(NUM_REGS)
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] y
);
  assign y = en ? NUM_REGS'(onehot(MAX_IDX_W'(idx))) : '0;
endmodule

// File: rtl/select_encode_scoreboard.sv
// select_encode_scoreboard: register field select/encode with write-pending scoreboard
module select_encode_scoreboard
  import select_encode_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W = $clog2(NUM_REGS),
  parameter int RA_LSB = RA_LSB_DEF,
  parameter int RB_LSB = RB_LSB_DEF,
  parameter int RC_LSB = RC_LSB_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] IR_data,
  input  logic                  IR_load,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic                  Rin,
  input  logic                  Rout,
  input  logic                  BAout,
  input  logic                  issue,
  input  logic                  wb_valid,
  input  logic [IDX_W-1:0]      wb_idx,
  output logic [NUM_REGS-1:0]   reg_in,
  output logic [NUM_REGS-1:0]   reg_out,
  output logic                  ba_zero,
  output logic [IDX_W-1:0]      sel_idx,
  output logic [NUM_REGS-1:0]   busy,
  output logic [IDX_W:0]        pend_cnt,
  output logic                  stall
);
  logic [IDX_W-1:0] ra, rb, rc;
  logic [NUM_REGS-1:0] busy_nxt, set_mask, clr_mask;
  logic [IDX_W:0] cnt_nxt;
  logic any_g, ir_unused;
  assign ir_unused = ^IR_data;
  assign any_g = Gra | Grb | Grc;
  assign sel_idx = Gra ? ra : Grb ? rb : Grc ? rc : '0;
  assign ba_zero = BAout & any_g & (sel_idx == '0);
  assign stall = (Grb & busy[rb]) | (Grc & busy[rc]) | (Gra & Rout & busy[ra]);
  onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_in_dec (
    .idx(sel_idx),
    .en (Rin & any_g),
    .y  (reg_in)
  );
  onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_out_dec (
    .idx(sel_idx),
    .en ((Rout | BAout) & any_g & ~ba_zero),
    .y  (reg_out)
  );
  assign set_mask = issue ? NUM_REGS'(onehot(MAX_IDX_W'(ra))) : '0;
  assign clr_mask = wb_valid ? NUM_REGS'(onehot(MAX_IDX_W'(wb_idx))) : '0;
  assign busy_nxt = (busy & ~clr_mask) | set_mask;
  // popcount of the next busy vector so the count lands with busy
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_nxt = cnt_nxt + (IDX_W+1)'(busy_nxt[i]);
  end
  // field latches and scoreboard state; issue sees ra from before a same-edge load
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ra <= '0;
      rb <= '0;
      rc <= '0;
      busy <= '0;
      pend_cnt <= '0;
    end else begin
      if (IR_load) begin
        ra <= IR_data[RA_LSB +: IDX_W];
        rb <= IR_data[RB_LSB +: IDX_W];
        rc <= IR_data[RC_LSB +: IDX_W];
      end
      busy <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end
endmodule

// File: doc/select_encode_scoreboard.md
SELECT_ENCODE_SCOREBOARD -- requirements
Module: select_encode_scoreboard

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 32, IR width; NUM_REGS 16, register count, power of two, 2..64; IDX_W $clog2(NUM_REGS), index width; RA_LSB 23, RB_LSB 19, RC_LSB 15, IR bit positions of the Ra/Rb/Rc fields.
REQ-002 Ports SHALL be:
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous active-high reset
- IR_data  in  DATA_WIDTH  instruction word
- IR_load  in  1  capture Ra/Rb/Rc fields from IR_data
- Gra, Grb, Grc  in  1 each  field selects
- Rin, Rout, BAout  in  1 each  register write, read and base-address-read strobes
- issue  in  1  mark the latched Ra register as write-pending
- wb_valid  in  1  writeback complete
- wb_idx  in  IDX_W  register whose pending write completed
- reg_in  out  NUM_REGS  one-hot register write enables
- reg_out  out  NUM_REGS  one-hot register read enables
- ba_zero  out  1  bus must carry constant zero
- sel_idx  out  IDX_W  currently selected index
- busy  out  NUM_REGS  write-pending bits
- pend_cnt  out  IDX_W+1  number of set busy bits
- stall  out  1  RAW hazard on a selected source
REQ-003 Clocking and reset are decided: one clock, clk; reset clr is asynchronous and active-high.

Function
REQ-004 On a clk edge with IR_load=1, the block SHALL register ra, rb and rc from IR_data[RA_LSB+:IDX_W], [RB_LSB+:IDX_W] and [RC_LSB+:IDX_W]. The new fields take effect in the cycle after the edge.
REQ-005 sel_idx SHALL be combinational and select by priority Gra > Grb > Grc: ra if Gra, else rb if Grb, else rc if Grc, else 0.
REQ-006 reg_in SHALL be the one-hot decode of sel_idx when Rin=1 and any Gr* is set, otherwise all-zero. A write to index 0 is permitted.
REQ-007 reg_out SHALL be the one-hot decode of sel_idx when (Rout|BAout)=1 and any Gr* is set, otherwise all-zero.
REQ-008 For BAout=1 with sel_idx=0 and any Gr* set, reg_out SHALL be all-zero and ba_zero=1. In every other case ba_zero SHALL be 0.
REQ-009 On a clk edge with issue=1, busy[ra] SHALL set.
REQ-010 On a clk edge with wb_valid=1, busy[wb_idx] SHALL clear.
REQ-011 If issue and wb_valid target the same index in the same cycle, the set SHALL win. Different indices SHALL both take effect.
REQ-012 If wb_valid names a register that is not busy, busy SHALL be unchanged (no error).
REQ-013 If issue targets a register that is already busy, the bit SHALL remain set. No count or depth is tracked per register.
REQ-014 pend_cnt SHALL be registered and equal the popcount of busy, updated in the same edge as busy.
REQ-015 stall SHALL be combinational: (Grb & busy[rb]) | (Grc & busy[rc]) | (Gra & Rout & busy[ra]). Gra with Rin alone SHALL NOT stall.
REQ-016 If IR_load and issue are asserted together, issue SHALL use the ra value from before that edge.

Reset
REQ-017 While clr=1, asynchronously: ra=rb=rc=0, busy=0, pend_cnt=0.
REQ-018 Under reset the combinational outputs SHALL follow REQ-005 to REQ-008 and REQ-015 using the zeroed state. With busy=0, stall=0.
REQ-019 A clr pulse during pending writes SHALL discard all busy bits. A later wb_valid for a discarded index is a no-op.

Structure
REQ-020 A shared package SHALL hold the default field LSB constants and the one-hot decode function. The one-hot decode is also usable by the datapath.
REQ-021 One sub-module, onehot_decoder (IDX_W to NUM_REGS, with enable), SHALL be instantiated twice, for reg_in and reg_out. The scoreboard stays in the top module.

Verification
REQ-022 IR_load with IR_data=0x01A8_8000 (ra=3, rb=5, rc=1), then Gra+Rin -> reg_in=0x0008. Then Grb+Rout -> reg_out=0x0020.
REQ-023 Gra+Grc+Rout with ra=3, rc=1 -> reg_out=0x0008 (priority to Gra).
REQ-024 ra=0, Gra+BAout -> reg_out=0, ba_zero=1. Same stimulus with Rout instead of BAout -> reg_out=0x0001, ba_zero=0.
REQ-025 issue with ra=5 -> busy=0x0020, pend_cnt=1. Then Grb+Rout with rb=5 -> stall=1. Then wb_valid with wb_idx=5 -> busy=0, stall=0.
REQ-026 issue with ra=7 and wb_valid with wb_idx=7 in the same cycle -> busy[7]=1. Then clr mid-cycle -> busy=0 and pend_cnt=0 immediately, without waiting for a clk edge.
